calendar_set_ctrl: RTL and testbench
====================================

// Module: calendar_set_ctrl
// PURPOSE
//  User-facing set-mode controller for the calendar counter. Walks the user through day/month/year
//  edit fields using pre-debounced button pulses, enforces calendar validity, and commits the result
//  to the calendar. The commit is a one-cycle date_ow pulse plus a stable date_set word
//  (ddddd_mmmm_y..y, same format as the calendar's date input).
// PARAMETERS
//  YEARRES      12        year field width; must match the calendar instance
//  BLINK_DIV    25000000  cycles per blink half-period for the field currently being edited
//  TIMEOUT_CYC  500000000 idle cycles before an edit is abandoned (used only with CAL_TIMEOUT_EN)
// PORTS
//  clk        in   1            system clock
//  rst_n      in   1            asynchronous active-low reset
//  btn_mode   in   1            1-cycle pulse: enter set mode / advance field
//  btn_up     in   1            1-cycle pulse: increment current field
//  btn_down   in   1            1-cycle pulse: decrement current field
//  date_cur   in   YEARRES+9    live date from calendar, sampled on edit entry
//  date_set   out  YEARRES+9    registered edit word {day,month,year}; driven to calendar date_in
//  date_ow    out  1            1-cycle commit pulse; driven to calendar date_ow
//  set_active out  1            high in every state except IDLE
//  field_sel  out  2            0=none 1=day 2=month 3=year
//  blink      out  1            display blank toggle for the selected field; 0 in IDLE
// BEHAVIOUR
//  - Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
//  - Reset values: state=IDLE, day=1, month=1, year=0, date_ow=0, set_active=0, field_sel=0, blink=0.
//  - FSM: IDLE -> SET_DAY -> SET_MONTH -> SET_YEAR -> COMMIT -> WRITE -> IDLE.
//  - IDLE: btn_mode loads the edit regs from date_cur and moves to SET_DAY in the next cycle.
//    Load sanitising: month 0 or >12 loads as 1; day 0 loads as 1.
//  - SET_* states: btn_mode advances to the next state.
//  - SET_DAY: up gives day==max ? 1 : day+1. Down gives day<=1 ? max : day-1.
//    max = days_in_month(month,year). Leap rule: year[1:0]==0, matching the calendar.
//    Sanitising: a day above max on entry is clamped to max on the first up/down.
//  - SET_MONTH: up wraps 12->1; down wraps 1->12.
//  - SET_YEAR: up/down wrap modulo 2^YEARRES.
//  - COMMIT (1 cycle): day <= min(day, max). Covers a month/year change that invalidates the day.
//  - WRITE (1 cycle): date_ow=1. date_set holds its value from COMMIT until the next edit entry.
//    Total latency from the final btn_mode to the date_ow pulse is 2 cycles.
//  - Priority: btn_mode over up/down in the same cycle (the up/down is dropped).
//    up and down together: no change. All buttons are ignored in COMMIT and WRITE.
//  - date_set is a direct register output, so it stays glitch-free while the calendar's async
//    overwrite is asserted.
//  - blink: counter runs only in SET_*; blink toggles every BLINK_DIV cycles.
//    Counter and blink clear to 0 on any field change and in IDLE.
//  - Reset mid-edit: returns to IDLE immediately, date_ow=0, no commit.
// CONFIGURATION
//  - CAL_TIMEOUT_EN defined: an inactivity counter clears on any button pulse.
//    It counts only in SET_* states. Reaching TIMEOUT_CYC forces IDLE with no date_ow (edit discarded).
//  - CAL_TIMEOUT_EN undefined: no counter; set mode persists indefinitely.
//    TIMEOUT_CYC is then unused.
// STRUCTURE
//  - Shared package calendar_pkg holds:
//    state encoding localparams; field codes FLD_NONE/DAY/MONTH/YEAR;
//    month constants (MON_FEB etc.); days_in_month function (month, year LSBs -> 5-bit max).
//  - One sub-module, cal_days_in_month: combinational max-day lookup. Reusable by the calendar itself.
// TESTING
//  1. rst_n=0 -> date_ow=0, set_active=0, field_sel=0, date_set={5'd1,4'd1,12'd0}.
//  2. date_cur=15/02/2023, mode, up x13 -> day=28; up again -> day=1; down -> day=28.
//  3. date_cur=28/02/2024 (leap), mode, up -> 29, up -> 1.
//  4. date_cur=31/01/2023, mode, mode, up (month=2), mode, mode
//     -> date_ow high exactly 1 cycle, 2 cycles after last mode;
//     date_set={5'd28,4'd2,12'd2023}.
//  5. Wrap: month 1 down -> 12. Year 0 down -> 4095. mode+up same cycle -> field advances, value unchanged.
//  6. CAL_TIMEOUT_EN, TIMEOUT_CYC=16: enter SET_MONTH, idle 16 cycles -> IDLE, no date_ow.
//     Without the macro -> still SET_MONTH. Also: rst_n pulse in SET_YEAR -> IDLE, no date_ow.

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared definitions for the calendar counter and its set-mode controller:
// state encoding, field codes, month constants and the days-in-month lookup.
package calendar_pkg;

    localparam int DAY_W = 5;
    localparam int MON_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SET_DAY   = 3'd1,
        ST_SET_MONTH = 3'd2,
        ST_SET_YEAR  = 3'd3,
        ST_COMMIT    = 3'd4,
        ST_WRITE     = 3'd5
    } cal_state_t;

    localparam logic [1:0] FLD_NONE  = 2'd0;
    localparam logic [1:0] FLD_DAY   = 2'd1;
    localparam logic [1:0] FLD_MONTH = 2'd2;
    localparam logic [1:0] FLD_YEAR  = 2'd3;

    localparam logic [MON_W-1:0] MON_JAN = 4'd1;
    localparam logic [MON_W-1:0] MON_FEB = 4'd2;
    localparam logic [MON_W-1:0] MON_MAR = 4'd3;
    localparam logic [MON_W-1:0] MON_APR = 4'd4;
    localparam logic [MON_W-1:0] MON_MAY = 4'd5;
    localparam logic [MON_W-1:0] MON_JUN = 4'd6;
    localparam logic [MON_W-1:0] MON_JUL = 4'd7;
    localparam logic [MON_W-1:0] MON_AUG = 4'd8;
    localparam logic [MON_W-1:0] MON_SEP = 4'd9;
    localparam logic [MON_W-1:0] MON_OCT = 4'd10;
    localparam logic [MON_W-1:0] MON_NOV = 4'd11;
    localparam logic [MON_W-1:0] MON_DEC = 4'd12;

    localparam logic [DAY_W-1:0] DAY_FIRST = 5'd1;

    // Leap years are those with year[1:0]==0, the same simplified rule the calendar uses.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                       input logic [1:0]       year_lsb);
        case (month)
            MON_FEB:                            return (year_lsb == 2'b00) ? 5'd29 : 5'd28;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: return 5'd30;
            default:                            return 5'd31;
        endcase
    endfunction

    function automatic logic is_set_state(input cal_state_t s);
        return (s == ST_SET_DAY) || (s == ST_SET_MONTH) || (s == ST_SET_YEAR);
    endfunction

endpackage

// File: rtl/calendar_set_ctrl_dim.sv
// Combinational maximum-day lookup for a month/year pair; shared with the calendar counter.
module cal_days_in_month
    import calendar_pkg::*;
(
    input  logic [MON_W-1:0] month,
    input  logic [1:0]       year_lsb,
    output logic [DAY_W-1:0] max_day
);

    assign max_day = days_in_month(month, year_lsb);

endmodule

// File: rtl/calendar_set_ctrl.sv
// User set-mode controller: edits day/month/year from button pulses and commits via date_set/date_ow.
// Optional inactivity abort: define CAL_TIMEOUT_EN to discard an edit idle for TIMEOUT_CYC cycles.
module calendar_set_ctrl
    import calendar_pkg::*;
#(
    parameter int YEARRES     = 12,
    parameter int BLINK_DIV   = 25000000,
    parameter int TIMEOUT_CYC = 500000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_mode,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic [YEARRES+8:0] date_cur,
    output logic [YEARRES+8:0] date_set,
    output logic               date_ow,
    output logic               set_active,
    output logic [1:0]         field_sel,
    output logic               blink
);

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    cal_state_t         state;
    logic [DAY_W-1:0]   day;
    logic [MON_W-1:0]   month;
    logic [YEARRES-1:0] year;

    logic [DAY_W-1:0]   cur_day;
    logic [MON_W-1:0]   cur_month;
    logic [YEARRES-1:0] cur_year;
    logic [DAY_W-1:0]   max_day;

    logic               in_set;
    logic               any_btn;
    logic               advance;
    logic               step_up;
    logic               step_down;
    logic               timed_out;
    logic [DAY_W-1:0]   day_up;
    logic [DAY_W-1:0]   day_down;
    logic [DAY_W-1:0]   day_clamped;
    logic [DAY_W-1:0]   load_day;
    logic [MON_W-1:0]   load_month;
    logic [MON_W-1:0]   month_up;
    logic [MON_W-1:0]   month_down;

    logic [BLINK_W-1:0] blink_cnt;

    assign {cur_day, cur_month, cur_year} = date_cur;

    // The edit registers drive the calendar directly, so date_set never glitches during overwrite.
    assign date_set = {day, month, year};

    cal_days_in_month u_dim (
        .month    (month),
        .year_lsb (year[1:0]),
        .max_day  (max_day)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        step_up     = 1'b0;
        step_down   = 1'b0;
        in_set      = is_set_state(state);
        any_btn     = btn_mode | btn_up | btn_down;
        advance     = in_set & btn_mode;

        // btn_mode wins over up/down; up and down together cancel.
        if (in_set && !btn_mode && (btn_up != btn_down)) begin
            step_up   = btn_up;
            step_down = btn_down;
        end

        day_clamped = (day > max_day) ? max_day : day;

        if (day > max_day)       day_up = max_day;
        else if (day == max_day) day_up = DAY_FIRST;
        else                     day_up = day + 5'd1;

        if (day > max_day)       day_down = max_day;
        else if (day <= 5'd1)    day_down = max_day;
        else                     day_down = day - 5'd1;

        month_up   = (month >= MON_DEC) ? MON_JAN : month + 4'd1;
        month_down = (month <= MON_JAN) ? MON_DEC : month - 4'd1;

        load_day   = (cur_day == '0) ? DAY_FIRST : cur_day;
        load_month = ((cur_month == '0) || (cur_month > MON_DEC)) ? MON_JAN : cur_month;
    end

`ifdef CAL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idle_cnt;

    assign timed_out = in_set && !any_btn && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!in_set || any_btn || timed_out) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            day        <= DAY_FIRST;
            month      <= MON_JAN;
            year       <= '0;
            date_ow    <= 1'b0;
            set_active <= 1'b0;
            field_sel  <= FLD_NONE;
        end else begin
            // NOTE: state uses <= so every flop samples pre-edge values, independent of statement order.
            date_ow <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (btn_mode) begin
                        day        <= load_day;
                        month      <= load_month;
                        year       <= cur_year;
                        state      <= ST_SET_DAY;
                        set_active <= 1'b1;
                        field_sel  <= FLD_DAY;
                    end
                end
                ST_SET_DAY: begin
                    if (advance) begin
                        state     <= ST_SET_MONTH;
                        field_sel <= FLD_MONTH;
                    end else if (step_up) begin
                        day <= day_up;
                    end else if (step_down) begin
                        day <= day_down;
                    end
                end
                ST_SET_MONTH: begin
                    if (advance) begin
                        state     <= ST_SET_YEAR;
                        field_sel <= FLD_YEAR;
                    end else if (step_up) begin
                        month <= month_up;
                    end else if (step_down) begin
                        month <= month_down;
                    end
                end
                ST_SET_YEAR: begin
                    if (advance) begin
                        state     <= ST_COMMIT;
                        field_sel <= FLD_NONE;
                    end else if (step_up) begin
                        year <= year + YEARRES'(1);
                    end else if (step_down) begin
                        year <= year - YEARRES'(1);
                    end
                end
                ST_COMMIT: begin
                    // A month or year change may have left the day beyond the new month's end.
                    day     <= day_clamped;
                    state   <= ST_WRITE;
                    date_ow <= 1'b1;
                end
                ST_WRITE: begin
                    state      <= ST_IDLE;
                    set_active <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    set_active <= 1'b0;
                    field_sel  <= FLD_NONE;
                end
            endcase

            if (timed_out) begin
                state      <= ST_IDLE;
                set_active <= 1'b0;
                field_sel  <= FLD_NONE;
            end
        end
    end

    // Blink phase restarts whenever the selected field changes so the new field starts visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (!in_set || advance || timed_out) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Directed bench for calendar_set_ctrl: hand-computed date edits, wraps, commit timing and aborts.
module tb_calendar_set_ctrl;

    localparam int YR = 12;
    localparam int BD = 4;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          btn_mode;
    logic          btn_up;
    logic          btn_down;
    logic [YR+8:0] date_cur;
    logic [YR+8:0] date_set;
    logic          date_ow;
    logic          set_active;
    logic [1:0]    field_sel;
    logic          blink;

    int total = 0;
    int bad   = 0;
    int ow_count = 0;
    int ow_ref;

    calendar_set_ctrl #(
        .YEARRES     (YR),
        .BLINK_DIV   (BD),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .date_cur   (date_cur),
        .date_set   (date_set),
        .date_ow    (date_ow),
        .set_active (set_active),
        .field_sel  (field_sel),
        .blink      (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (date_ow === 1'b1) ow_count++;

    function automatic logic [YR+8:0] mk(input int d, input int m, input int y);
        logic [4:0]    dd;
        logic [3:0]    mm;
        logic [YR-1:0] yy;
        dd = d[4:0];
        mm = m[3:0];
        yy = y[YR-1:0];
        return {dd, mm, yy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    task automatic enter(input logic [YR+8:0] d);
        date_cur = d;
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        date_cur = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ow", date_ow, 0);
        check("rst_active", set_active, 0);
        check("rst_field", field_sel, 0);
        check("rst_blink", blink, 0);
        check("rst_date", date_set, mk(1, 1, 0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_active", set_active, 0);

        // February 2023: 28-day wrap both ways
        enter(mk(15, 2, 2023));
        check("entry_field", field_sel, 1);
        check("entry_active", set_active, 1);
        check("entry_date", date_set, mk(15, 2, 2023));
        repeat (13) press(1'b0, 1'b1, 1'b0);
        check("feb_up13", date_set[20:16], 28);
        press(1'b0, 1'b1, 1'b0);
        check("feb_wrap_up", date_set[20:16], 1);
        press(1'b0, 1'b0, 1'b1);
        check("feb_wrap_down", date_set[20:16], 28);
        apply_reset();
        check("reset_no_commit", date_set, mk(1, 1, 0));

        // Leap February 2024
        enter(mk(28, 2, 2024));
        press(1'b0, 1'b1, 1'b0);
        check("leap_29", date_set[20:16], 29);
        press(1'b0, 1'b1, 1'b0);
        check("leap_wrap", date_set[20:16], 1);
        press(1'b0, 1'b0, 1'b1);
        check("leap_down", date_set[20:16], 29);
        apply_reset();

        // Sanitising on load and on first step
        enter(mk(0, 13, 5));
        check("load_sanitise", date_set, mk(1, 1, 5));
        apply_reset();
        enter(mk(31, 4, 2023));
        press(1'b0, 1'b1, 1'b0);
        check("clamp_first_up", date_set[20:16], 30);
        apply_reset();

        // Blink: toggles after BD cycles in a field, clears on field advance
        enter(mk(10, 3, 2020));
        repeat (3) @(negedge clk);
        check("blink_low", blink, 0);
        @(negedge clk);
        check("blink_high", blink, 1);
        press(1'b1, 1'b0, 1'b0);
        check("blink_clear", blink, 0);
        apply_reset();

        // Commit 31/01/2023 -> February: day clamped, 2-cycle latency, 1-cycle pulse
        enter(mk(31, 1, 2023));
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("month_to_feb", date_set[15:12], 2);
        press(1'b1, 1'b0, 1'b0);
        ow_ref = ow_count;
        press(1'b1, 1'b0, 1'b0);
        check("commit_ow0", date_ow, 0);
        check("commit_active", set_active, 1);
        check("commit_field", field_sel, 0);
        @(negedge clk);
        check("write_ow1", date_ow, 1);
        check("write_date", date_set, mk(28, 2, 2023));
        @(negedge clk);
        check("after_ow0", date_ow, 0);
        check("after_active", set_active, 0);
        check("after_hold", date_set, mk(28, 2, 2023));
        repeat (2) @(negedge clk);
        check("one_pulse", ow_count, ow_ref + 1);

        // Wraps and button priority
        apply_reset();
        enter(mk(10, 1, 0));
        press(1'b1, 1'b1, 1'b0);
        check("prio_field", field_sel, 2);
        check("prio_value", date_set, mk(10, 1, 0));
        press(1'b0, 1'b1, 1'b1);
        check("updown_nop", date_set[15:12], 1);
        press(1'b0, 1'b0, 1'b1);
        check("month_wrap", date_set[15:12], 12);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("year_wrap_dn", date_set[11:0], 4095);
        press(1'b0, 1'b1, 1'b0);
        check("year_wrap_up", date_set[11:0], 0);
        apply_reset();

        // Inactivity in SET_MONTH
        enter(mk(5, 6, 2000));
        press(1'b1, 1'b0, 1'b0);
        ow_ref = ow_count;
        repeat (TO - 1) @(negedge clk);
        check("idle_15", field_sel, 2);
        @(negedge clk);
`ifdef CAL_TIMEOUT_EN
        check("timeout_field", field_sel, 0);
        check("timeout_active", set_active, 0);
`else
        check("persist_field", field_sel, 2);
        check("persist_active", set_active, 1);
`endif
        check("timeout_no_ow", ow_count, ow_ref);

        // Asynchronous reset in SET_YEAR
        apply_reset();
        enter(mk(7, 8, 1999));
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("year_field", field_sel, 3);
        ow_ref = ow_count;
        #2 rst_n = 1'b0;
        #1;
        check("async_active", set_active, 0);
        check("async_field", field_sel, 0);
        check("async_ow", date_ow, 0);
        check("async_date", date_set, mk(1, 1, 0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_commit", ow_count, ow_ref);
        check("rst_idle", set_active, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
